// File: rtl/decode_issue.sv
// decode_issue: single-slot decode stage with register file, write-through bypass
// and a one-bubble load-use interlock.
module decode_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            F_valid,
    input  logic [31:0]     F_instr,
    input  logic [XLEN-1:0] F_pc,
    input  logic            flush,
    input  logic [4:0]      EX_rd,
    input  logic            EX_ld,
    input  logic            WB_we,
    input  logic [4:0]      WB_rd,
    input  logic [XLEN-1:0] WB_data,
    output logic [XLEN-1:0] D_a,
    output logic [XLEN-1:0] D_a2,
    output logic [XLEN-1:0] D_b,
    output logic [XLEN-1:0] D_b2,
    output logic [3:0]      D_alu_op,
    output logic [4:0]      D_rd,
    output logic            D_ld,
    output logic            D_str,
    output logic            D_we,
    output logic            D_brn,
    output logic            stall_F,
    output logic [15:0]     stall_cnt
);
    typedef enum logic {ISSUE, STALL} state_t;

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_rf [32];
    logic [15:0]     r_stall_cnt;

    logic [3:0]      w_alu_op;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic            w_imm_sel, w_ld, w_str, w_brn;
    logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val;
    logic            w_hz, w_issue, w_inc, w_wr;

    assign w_alu_op  = F_instr[3:0];
    assign w_rd      = F_instr[8:4];
    assign w_rs1     = F_instr[13:9];
    assign w_rs2     = F_instr[18:14];
    assign w_imm_sel = F_instr[19];
    assign w_ld      = F_instr[20];
    assign w_str     = F_instr[21];
    assign w_brn     = F_instr[22];
    assign w_imm     = {{(XLEN-9){F_instr[31]}}, F_instr[31:23]};

    // Writes are blocked in reset so the bypass must be blocked too.
    assign w_wr      = WB_we && WB_rd != 5'd0 && !rst;
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : (w_wr && WB_rd == w_rs1) ? WB_data : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : (w_wr && WB_rd == w_rs2) ? WB_data : r_rf[w_rs2];

    // rs2 only matters when it is actually read: reg operand, store data or branch compare.
    assign w_hz = F_valid && EX_ld && EX_rd != 5'd0 &&
                  (EX_rd == w_rs1 || (EX_rd == w_rs2 && (!w_imm_sel || w_str || w_brn)));

    always_comb begin
        w_next  = ISSUE;
        w_issue = 1'b0;
        w_inc   = 1'b0;
        stall_F = 1'b0;
        if (rst || flush) begin
            w_next = ISSUE;
        end else if (r_state == STALL) begin
            w_issue = F_valid;
        end else if (w_hz) begin
            stall_F = 1'b1;
            w_inc   = 1'b1;
            w_next  = STALL;
        end else begin
            w_issue = F_valid;
        end
    end

    assign D_a       = w_issue ? w_rs1_val : '0;
    assign D_a2      = w_issue ? F_pc : '0;
    assign D_b       = w_issue ? (w_imm_sel ? w_imm : w_rs2_val) : '0;
    assign D_b2      = w_issue ? w_rs2_val : '0;
    assign D_alu_op  = w_issue ? w_alu_op : 4'd0;
    assign D_ld      = w_issue && w_ld;
    assign D_str     = w_issue && w_str;
    assign D_brn     = w_issue && w_brn;
    assign D_we      = w_issue && !w_str && !w_brn && w_rd != 5'd0;
    assign D_rd      = (D_we || D_ld) ? w_rd : 5'd0;
    // The count already reflects the bubble being inserted this cycle.
    assign stall_cnt = rst ? 16'd0 : (w_inc && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ISSUE;
            r_stall_cnt <= 16'd0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            r_state     <= w_next;
            r_stall_cnt <= stall_cnt;
            if (w_wr) r_rf[WB_rd] <= WB_data;
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed vectors push expected decode outputs into a queue;
// a negedge monitor pops and compares them against the DUT.
module tb_decode_issue;
    typedef struct packed {
        logic [31:0] a, a2, b, b2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        ld, str, we, brn, sf;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, F_valid = 1'b0, flush = 1'b0, EX_ld = 1'b0, WB_we = 1'b0;
    logic [31:0] F_instr = '0, F_pc = '0, WB_data = '0;
    logic [4:0]  EX_rd = '0, WB_rd = '0;
    logic [31:0] D_a, D_a2, D_b, D_b2;
    logic [3:0]  D_alu_op;
    logic [4:0]  D_rd;
    logic        D_ld, D_str, D_we, D_brn, stall_F;
    logic [15:0] stall_cnt;

    exp_t q[$];
    int   n_vec = 0, n_bad = 0;

    decode_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .F_valid(F_valid), .F_instr(F_instr), .F_pc(F_pc),
        .flush(flush), .EX_rd(EX_rd), .EX_ld(EX_ld), .WB_we(WB_we), .WB_rd(WB_rd),
        .WB_data(WB_data), .D_a(D_a), .D_a2(D_a2), .D_b(D_b), .D_b2(D_b2),
        .D_alu_op(D_alu_op), .D_rd(D_rd), .D_ld(D_ld), .D_str(D_str), .D_we(D_we),
        .D_brn(D_brn), .stall_F(stall_F), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] I(input logic [3:0] alu, input logic [4:0] rd, rs1, rs2,
                                      input logic isel, ld, str, brn, input logic [8:0] imm);
        return {imm, brn, str, ld, isel, rs2, rs1, rd, alu};
    endfunction

    function automatic exp_t E(input logic [31:0] a, a2, b, b2, input logic [3:0] alu,
                               input logic [4:0] rd, input logic ld, str, we, brn, sf,
                               input logic [15:0] cnt);
        return '{a, a2, b, b2, alu, rd, ld, str, we, brn, sf, cnt};
    endfunction

    function automatic exp_t BUB(input logic sf, input logic [15:0] cnt);
        return E(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sf, cnt);
    endfunction

    task automatic vec(input logic r, fv, input logic [31:0] ins, pc, input logic fl, exld,
                       input logic [4:0] exrd, input logic wbwe, input logic [4:0] wbrd,
                       input logic [31:0] wbd, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; F_valid = fv; F_instr = ins; F_pc = pc; flush = fl;
        EX_ld = exld; EX_rd = exrd; WB_we = wbwe; WB_rd = wbrd; WB_data = wbd;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, act;
            e   = q.pop_front();
            act = '{D_a, D_a2, D_b, D_b2, D_alu_op, D_rd, D_ld, D_str, D_we, D_brn, stall_F, stall_cnt};
            n_vec++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL vec%0d: got a=%h a2=%h b=%h b2=%h alu=%h rd=%0d ld=%b st=%b we=%b br=%b sf=%b cnt=%h, want a=%h a2=%h b=%h b2=%h alu=%h rd=%0d ld=%b st=%b we=%b br=%b sf=%b cnt=%h",
                         n_vec, act.a, act.a2, act.b, act.b2, act.alu, act.rd, act.ld, act.str, act.we, act.brn, act.sf, act.cnt,
                         e.a, e.a2, e.b, e.b2, e.alu, e.rd, e.ld, e.str, e.we, e.brn, e.sf, e.cnt);
            end
        end
    end

    initial begin
        // reset: WB write to x6 must be ignored
        vec(1, 1, I(3, 7, 6, 0, 0, 0, 0, 0, 0), 'h100, 0, 0, 0, 1, 6, 'hDEAD, BUB(0, 0));
        vec(1, 1, I(3, 7, 6, 0, 0, 0, 0, 0, 0), 'h100, 0, 0, 0, 1, 6, 'hDEAD, BUB(0, 0));
        vec(0, 1, I(1, 2, 6, 0, 0, 0, 0, 0, 0), 'h100, 0, 0, 0, 1, 5, 'h1234, E(0, 'h100, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0));
        vec(0, 1, I(3, 7, 5, 0, 0, 0, 0, 0, 0), 'h104, 0, 0, 0, 0, 0, 0, E('h1234, 'h104, 0, 0, 3, 7, 0, 0, 1, 0, 0, 0));
        // bypass on rs1, rs2 from file
        vec(0, 1, I(2, 3, 9, 5, 0, 0, 0, 0, 0), 'h108, 0, 0, 0, 1, 9, 'hA5A5, E('hA5A5, 'h108, 'h1234, 'h1234, 2, 3, 0, 0, 1, 0, 0, 0));
        vec(0, 1, I(4, 1, 0, 9, 0, 0, 0, 0, 0), 'h10C, 0, 0, 0, 1, 0, 'hFFFF, E(0, 'h10C, 'hA5A5, 'hA5A5, 4, 1, 0, 0, 1, 0, 0, 0));
        vec(0, 1, I(5, 0, 0, 0, 0, 0, 0, 0, 0), 'h110, 0, 0, 0, 0, 0, 0, E(0, 'h110, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
        // store with immediate
        vec(0, 1, I(6, 4, 5, 9, 1, 0, 1, 0, 9'h010), 'h114, 0, 0, 0, 0, 0, 0, E('h1234, 'h114, 'h10, 'hA5A5, 6, 0, 0, 1, 0, 0, 0, 0));
        // load-use on rs2
        vec(0, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h118, 0, 1, 4, 0, 0, 0, BUB(1, 1));
        vec(0, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h118, 0, 1, 4, 0, 0, 0, E(0, 'h118, 0, 0, 7, 8, 0, 0, 1, 0, 0, 1));
        // imm_sel hides rs2
        vec(0, 1, I(8, 10, 0, 4, 1, 0, 0, 0, 9'h1FF), 'h11C, 0, 1, 4, 0, 0, 0, E(0, 'h11C, 'hFFFFFFFF, 0, 8, 10, 0, 0, 1, 0, 0, 1));
        // rs1 hazard, flush in STALL, then re-stall
        vec(0, 1, I(9, 11, 4, 0, 1, 0, 0, 0, 9'h005), 'h120, 0, 1, 4, 0, 0, 0, BUB(1, 2));
        vec(0, 1, I(9, 11, 4, 0, 1, 0, 0, 0, 9'h005), 'h120, 1, 1, 4, 0, 0, 0, BUB(0, 2));
        vec(0, 1, I(9, 11, 4, 0, 1, 0, 0, 0, 9'h005), 'h120, 0, 1, 4, 0, 0, 0, BUB(1, 3));
        vec(0, 1, I(9, 11, 4, 0, 1, 0, 0, 0, 9'h005), 'h120, 0, 1, 4, 0, 0, 0, E(0, 'h120, 5, 0, 9, 11, 0, 0, 1, 0, 0, 3));
        // flush during a hazard cycle in ISSUE
        vec(0, 1, I(9, 11, 4, 0, 1, 0, 0, 0, 9'h005), 'h120, 1, 1, 4, 0, 0, 0, BUB(0, 3));
        vec(0, 1, I(9, 11, 4, 0, 1, 0, 0, 0, 9'h005), 'h120, 0, 1, 4, 0, 0, 0, BUB(1, 4));
        vec(0, 1, I(9, 11, 4, 0, 1, 0, 0, 0, 9'h005), 'h120, 0, 1, 4, 0, 0, 0, E(0, 'h120, 5, 0, 9, 11, 0, 0, 1, 0, 0, 4));
        // branch reads rs2 even with imm_sel
        vec(0, 1, I(1, 3, 5, 9, 1, 0, 0, 1, 9'h100), 'h124, 0, 1, 9, 0, 0, 0, BUB(1, 5));
        vec(0, 1, I(1, 3, 5, 9, 1, 0, 0, 1, 9'h100), 'h124, 0, 1, 9, 0, 0, 0, E('h1234, 'h124, 'hFFFFFF00, 'hA5A5, 1, 0, 0, 0, 0, 1, 0, 5));
        // invalid fetch, load, EX_rd=0
        vec(0, 0, I(0, 1, 4, 0, 0, 0, 0, 0, 0), 'h128, 0, 1, 4, 0, 0, 0, BUB(0, 5));
        vec(0, 1, I(2, 12, 5, 0, 1, 1, 0, 0, 9'h004), 'h128, 0, 0, 0, 0, 0, 0, E('h1234, 'h128, 4, 0, 2, 12, 1, 0, 1, 0, 0, 5));
        vec(0, 1, I(3, 13, 0, 0, 0, 0, 0, 0, 0), 'h12C, 0, 1, 0, 0, 0, 0, E(0, 'h12C, 0, 0, 3, 13, 0, 0, 1, 0, 0, 5));
        // saturation: preload near the top instead of 65k stalls
        @(negedge clk);
        #1;
        force dut.r_stall_cnt = 16'hFFFE;
        #1;
        release dut.r_stall_cnt;
        vec(0, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h130, 0, 1, 4, 0, 0, 0, BUB(1, 16'hFFFF));
        vec(0, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h130, 0, 1, 4, 0, 0, 0, E(0, 'h130, 0, 0, 7, 8, 0, 0, 1, 0, 0, 16'hFFFF));
        vec(0, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h130, 0, 1, 4, 0, 0, 0, BUB(1, 16'hFFFF));
        // reset mid-STALL: no held issue afterwards
        vec(1, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h130, 0, 1, 4, 0, 0, 0, BUB(0, 0));
        vec(0, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h130, 0, 1, 4, 0, 0, 0, BUB(1, 1));
        vec(0, 1, I(7, 8, 0, 4, 0, 0, 0, 0, 0), 'h130, 0, 1, 4, 0, 0, 0, E(0, 'h130, 0, 0, 7, 8, 0, 0, 1, 0, 0, 1));
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands, register file entries and PC.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 F_valid  input  1  fetch presents a valid instruction.
REQ-005 F_instr  input  32  instruction word.
REQ-006 F_pc  input  XLEN  PC of F_instr.
REQ-007 flush  input  1  taken branch resolved in EX; kill the instruction in decode.
REQ-008 EX_rd  input  5  destination register of the instruction currently in EX.
REQ-009 EX_ld  input  1  instruction in EX is a load.
REQ-010 WB_we  input  1  writeback enable.
REQ-011 WB_rd  input  5  writeback register index.
REQ-012 WB_data  input  XLEN  writeback value.
REQ-013 D_a, D_a2, D_b, D_b2  output  XLEN each  operands to the D-to-EX register.
REQ-014 D_alu_op  output  4  ALU opcode.
REQ-015 D_rd  output  5  destination register.
REQ-016 D_ld, D_str, D_we, D_brn  output  1 each  load, store, register-write and branch flags.
REQ-017 stall_F  output  1  hold fetch (F_instr and F_pc) for the current cycle.
REQ-018 stall_cnt  output  16  saturating count of load-use bubbles inserted.

Function
REQ-019 Instruction fields: alu_op=[3:0], rd=[8:4], rs1=[13:9], rs2=[18:14], imm_sel=[19], ld=[20], str=[21], brn=[22], imm=sign-extended [31:23] to XLEN.
REQ-020 Register file: 32 x XLEN; x0 reads 0 and ignores writes; write on posedge clk when WB_we=1 and WB_rd!=0.
REQ-021 Write-through bypass: a same-cycle read of WB_rd (non-zero, WB_we=1) returns WB_data.
REQ-022 Operand mapping: D_a=rf[rs1]; D_b=imm if imm_sel else rf[rs2]; D_a2=F_pc; D_b2=rf[rs2].
REQ-023 D_we=1 for a valid non-store, non-branch instruction with rd!=0; D_rd=rd when D_we or D_ld is set, else 0.
REQ-024 Decode outputs are combinational from F_instr, F_pc and register-file state; zero added latency.
REQ-025 Bubble: D_alu_op=0, D_rd=0, D_ld=D_str=D_we=D_brn=0; operand outputs are 0.
REQ-026 Hazard: hz = F_valid & EX_ld & EX_rd!=0 & (EX_rd==rs1 | (EX_rd==rs2 & (!imm_sel | str | brn))).
REQ-027 FSM has two states, ISSUE and STALL; reset state is ISSUE.
REQ-028 ISSUE with hz=1 and flush=0: emit a bubble, stall_F=1, go to STALL, increment stall_cnt.
REQ-029 ISSUE with hz=0: emit the decoded instruction (or a bubble if F_valid=0), stall_F=0, stay in ISSUE.
REQ-030 STALL: emit the decoded held instruction unconditionally (at most one bubble per load-use), stall_F=0, return to ISSUE.
REQ-031 flush=1 in any state: emit a bubble, stall_F=0, next state ISSUE, stall_cnt unchanged; flush takes priority over hz.
REQ-032 stall_cnt saturates at 16'hFFFF.

Reset
REQ-033 While rst=1: outputs are a bubble, stall_F=0, stall_cnt=0, state ISSUE, all 32 register-file entries are 0; WB writes are ignored.
REQ-034 rst asserted during STALL returns to ISSUE on the next edge, with no held-instruction issue.

Verification
REQ-035 After reset, WB writes x5=0x1234; next cycle instr rs1=5, rs2=0, imm_sel=0, alu_op=3, rd=7 -> D_a=0x1234, D_b=0, D_we=1, D_rd=7, D_alu_op=3.
REQ-036 Same cycle WB_we=1, WB_rd=9, WB_data=0xA5A5, and instr rs1=9 -> D_a=0xA5A5 (bypass); WB_rd=0 write -> x0 still reads 0.
REQ-037 EX_ld=1, EX_rd=4, instr rs2=4, imm_sel=0 -> cycle 1: bubble, stall_F=1, stall_cnt=1; cycle 2: instruction issued, stall_F=0.
REQ-038 Hazard cycle with flush=1 -> bubble, stall_F=0, stall_cnt unchanged, state ISSUE.
REQ-039 instr imm_sel=1, imm field 9'h1FF, rs2=4, EX_ld=1, EX_rd=4, not store or branch -> no stall; D_b=0xFFFFFFFF.
REQ-040 Force stall_cnt to 0xFFFF via repeated load-use hazards -> stays 0xFFFF; rst mid-STALL -> all outputs bubble, stall_cnt=0.
